// File: rtl/alu_mul_seq_pkg.sv
// Shared encodings for the shift-add multiply sequencer: FSM states, funct select
// and the core's ALU function code used for the accumulator additions.
package alu_mul_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        FUNCT_MUL   = 1'b0,
        FUNCT_MULHU = 1'b1
    } funct_t;

    // Core ALU function code for ADD
    localparam logic [3:0] ALU_ADD = 4'd0;

    // Carry out of a 32-bit add, recovered from the wrapped sum
    function automatic logic add_carry(input logic [31:0] sum, input logic [31:0] addend);
        return (sum < addend);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned multiplier (MUL / MULHU) built from 32 shift-add steps
// that borrow the core's shared ALU for each addition.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_func,
    input  logic [31:0] alu_out
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_mcand;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [5:0]  r_cnt;
    logic        r_fsel;
    logic        r_done;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_zero;
    logic        w_step;
    logic        w_last;
    logic [31:0] w_sum;
    logic        w_carry;
    logic [31:0] w_hi_next;
    logic [31:0] w_lo_next;

    // Request acceptance, iteration enable and one shift-add step
    always_comb begin
        w_accept  = (r_state == ST_IDLE) && start && !flush;
        w_zero    = (a == 32'd0) || (b == 32'd0);
        w_step    = (r_state == ST_CALC) && alu_gnt && !flush;
        w_last    = w_step && (r_cnt == 6'd31);
        w_sum     = r_hi;
        w_carry   = 1'b0;
        if (r_lo[0]) begin
            w_sum   = alu_out;
            w_carry = add_carry(alu_out, r_hi);
        end else begin
            w_sum   = r_hi;
            w_carry = 1'b0;
        end
        w_hi_next = {w_carry, w_sum[31:1]};
        w_lo_next = {w_sum[0], r_lo[31:1]};
    end

    // Next-state logic; flush in CALC or DONE returns straight to IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_zero ? ST_DONE : ST_CALC;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    w_next_state = ST_IDLE;
                end else if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_CALC;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture and accumulator shifting; a stalled step holds everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_cnt   <= 6'd0;
            r_fsel  <= 1'b0;
        end else if (w_accept) begin
            r_mcand <= a;
            r_hi    <= 32'd0;
            r_lo    <= b;
            r_cnt   <= 6'd0;
            r_fsel  <= funct;
        end else if (w_step) begin
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_cnt   <= r_cnt + 6'd1;
        end else begin
            r_hi    <= r_hi;
            r_lo    <= r_lo;
            r_cnt   <= r_cnt;
        end
    end

    // Registered done pulse and result, loaded on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done   <= 1'b0;
            r_result <= 32'd0;
        end else if (w_accept && w_zero) begin
            r_done   <= 1'b1;
            r_result <= 32'd0;
        end else if (w_last && !flush) begin
            r_done   <= 1'b1;
            r_result <= (r_fsel == FUNCT_MULHU) ? w_hi_next : w_lo_next;
        end else begin
            r_done   <= 1'b0;
            r_result <= r_result;
        end
    end

    // Status and ALU operand decode from the state register
    always_comb begin
        busy     = 1'b0;
        alu_req  = 1'b0;
        alu_op1  = 32'd0;
        alu_op2  = 32'd0;
        alu_func = 4'd0;
        case (r_state)
            ST_CALC: begin
                busy     = 1'b1;
                alu_req  = 1'b1;
                alu_op1  = r_hi;
                alu_op2  = r_mcand;
                alu_func = ALU_ADD;
            end
            ST_DONE: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: stimulus pushes expected products and done
// latencies, a negedge monitor pops and checks them on every done pulse.
module tb_alu_mul_seq;
    import alu_mul_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_func;
    logic [31:0] alu_out;

    typedef struct packed {
        logic [31:0] res;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] last_result = 32'd0;

    alu_mul_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .funct    (funct),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .alu_req  (alu_req),
        .alu_gnt  (alu_gnt),
        .alu_op1  (alu_op1),
        .alu_op2  (alu_op2),
        .alu_func (alu_func),
        .alu_out  (alu_out)
    );

    // Shared ALU model
    assign alu_out = (alu_func == ALU_ADD) ? (alu_op1 + alu_op2) : 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic f);
        logic [63:0] p;
        p = {32'd0, x} * {32'd0, y};
        return f ? p[63:32] : p[31:0];
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", result, e.res);
                chk("done_latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
            end
        end
    end

    // One multiply; gnt is dropped for stall_len cycles starting at CALC cycle stall_at
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic f,
                          input int stall_at, input int stall_len);
        exp_t        e;
        int          k;
        logic [31:0] op1_hold;
        bit          idle_seen;
        @(negedge clk);
        a = x; b = y; funct = f; start = 1'b1; alu_gnt = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = ((x == 32'd0) || (y == 32'd0)) ? 1 : 33 + stall_len;
        e.res = ref_mul(x, y, f);
        e.start_cyc = cyc;
        e.lat = k;
        sb_q.push_back(e);
        last_result = e.res;
        op1_hold = 32'd0;
        idle_seen = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            alu_gnt = !(stall_len > 0 && i >= stall_at && i < stall_at + stall_len);
            if (!alu_gnt) begin
                chk("stall_req", {31'd0, alu_req}, 32'd1);
                chk("stall_op2", alu_op2, x);
                if (i == stall_at) op1_hold = alu_op1;
                else chk("stall_op1", alu_op1, op1_hold);
            end
            if (!busy) begin
                chk("busy_fall", 32'(i), 32'(k + 1));
                chk("result_hold", result, e.res);
                idle_seen = 1'b1;
                break;
            end
        end
        if (!idle_seen) chk("op_timeout", 32'd1, 32'd0);
        alu_gnt = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; funct = 1'b0; a = 32'd0; b = 32'd0;
        flush = 1'b0; alu_gnt = 1'b1;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_req", {31'd0, alu_req}, 32'd0);
        chk("rst_op1", alu_op1, 32'd0);
        chk("rst_op2", alu_op2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd3, 32'd5, 1'b0, 0, 0);
        chk("mul_3x5", last_result, 32'h0000000F);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 0);
        chk("mulhu_max", last_result, 32'hFFFFFFFE);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 0);
        chk("mul_max", last_result, 32'h00000001);
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 10, 10);
        chk("mulhu_stall", last_result, 32'h0B00EA4E);
        run_op(32'd0, 32'd7, 1'b0, 0, 0);
        run_op(32'd7, 32'd0, 1'b1, 0, 0);

        // Flush at CALC cycle 5
        @(negedge clk);
        a = 32'h1234; b = 32'h5678; funct = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_result", result, last_result);
        // Start together with flush in IDLE is rejected
        start = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("flush_start_result", result, last_result);

        // Asynchronous reset at CALC cycle 20
        @(negedge clk);
        a = 32'hABCDEF01; b = 32'h13579BDF; funct = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_req", {31'd0, alu_req}, 32'd0);
        chk("arst_op1", alu_op1, 32'd0);
        chk("arst_op2", alu_op2, 32'd0);
        chk("arst_func", {28'd0, alu_func}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_result = 32'd0;
        run_op(32'd3, 32'd5, 1'b0, 0, 0);
        chk("post_rst_3x5", last_result, 32'd15);

        for (int n = 0; n < 20; n++) begin
            logic [31:0] x;
            logic [31:0] y;
            int          sl;
            x = $urandom();
            y = $urandom();
            if ($urandom_range(0, 7) == 0) x = 32'd0;
            if ($urandom_range(0, 7) == 0) y = 32'd0;
            sl = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
            run_op(x, y, 1'($urandom_range(0, 1)), $urandom_range(2, 20), sl);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
